// File: rtl/scaler_axis_cfggen_pkg.sv
// Shared constants for the per-axis scaler config generator: FSM encoding,
// reciprocal precision and the vertical/horizontal port widths.
package scaler_axis_cfggen_pkg;

    localparam int FRAC_W_DEF = 17;

    localparam int V_N_IN_W  = 10;
    localparam int V_N_OUT_W = 11;
    localparam int H_N_IN_W  = 10;
    localparam int H_N_OUT_W = 12;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CAP  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_MUL1 = 3'd3;
    localparam logic [2:0] ST_MUL2 = 3'd4;
    localparam logic [2:0] ST_CALC = 3'd5;
    localparam logic [2:0] ST_PEND = 3'd6;

endpackage

// File: rtl/scaler_recip_div.sv
// Restoring serial divider computing floor(2^FRAC_W / divisor), one quotient bit per cycle.
// FRAC_W+1 cycles after start; done flags the final iteration, quot is valid the cycle after.
module scaler_recip_div #(
    parameter int FRAC_W = 17,
    parameter int DIV_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [FRAC_W:0]  quot
);

    localparam int CNT_W = $clog2(FRAC_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dsr;
    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;
    logic             ge;

    // The dividend is a single 1 at bit FRAC_W, so only the first shift brings in a one.
    always_comb begin
        trial = {rem, (cnt == CNT_W'(FRAC_W))};
        diff  = trial - {1'b0, dsr};
        ge    = ~diff[DIV_W];
    end

    assign done = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dsr  <= '0;
            quot <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(FRAC_W);
            rem  <= '0;
            dsr  <= divisor;
            quot <= '0;
        end else if (busy) begin
            rem  <= ge ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
            quot <= {quot[FRAC_W-1:0], ge};
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/scaler_axis_cfggen.sv
// Single-axis scaler config generator: reciprocal, samples needed and first sample, committed on apply_i.
// CAP + (FRAC_W+1) DIV + MUL1/MUL2/CALC before PEND; CFGGEN_POS_OFFSET_EN adds a clamped pos_offset_i.
module scaler_axis_cfggen
    import scaler_axis_cfggen_pkg::*;
#(
    parameter int N_IN_W  = H_N_IN_W,
    parameter int N_OUT_W = H_N_OUT_W,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RST,
    input  logic [N_IN_W-1:0]   n_in_full_i,
    input  logic [N_OUT_W-1:0]  n_out_i,
    input  logic [N_OUT_W-1:0]  n_active_i,
`ifdef CFGGEN_POS_OFFSET_EN
    input  logic signed [N_IN_W:0] pos_offset_i,
`endif
    input  logic                force_i,
    input  logic                apply_i,
    output logic                busy_o,
    output logic                pending_o,
    output logic                updated_o,
    output logic                err_o,
    output logic [FRAC_W:0]     interp_factor_o,
    output logic [N_IN_W-1:0]   n_in_needed_o,
    output logic [N_IN_W-1:0]   n_in_full_o,
    output logic [N_OUT_W-1:0]  n_out_o,
    output logic [N_IN_W-1:0]   pos_1st_o
);

    localparam int INV_W  = FRAC_W + 1 + N_IN_W;
    localparam int PROD_W = INV_W + N_OUT_W;
    localparam int RAW_W  = PROD_W + 1 - FRAC_W;
    localparam logic [PROD_W:0] HALF = (PROD_W + 1)'(1) << (FRAC_W - 1);

    logic [2:0]         state;
    logic [N_IN_W-1:0]  lat_in;
    logic [N_OUT_W-1:0] lat_out;
    logic [N_OUT_W-1:0] lat_act;
`ifdef CFGGEN_POS_OFFSET_EN
    logic signed [N_IN_W:0]   lat_off;
    logic signed [N_IN_W+1:0] pos_sum;
    logic [N_IN_W-1:0]        pos_lim;
`endif
    logic               changed;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [FRAC_W:0]    recip;
    logic [INV_W-1:0]   inv;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W:0]    rnd;
    logic [RAW_W-1:0]   raw;
    logic [N_IN_W-1:0]  needed_c;
    logic [N_IN_W-1:0]  pos_base;
    logic [N_IN_W-1:0]  pos_c;
    logic [N_IN_W-1:0]  res_needed;
    logic [N_IN_W-1:0]  res_pos;

    always_comb begin
        changed = (n_in_full_i != lat_in) || (n_out_i != lat_out) || (n_active_i != lat_act);
`ifdef CFGGEN_POS_OFFSET_EN
        changed = changed || (pos_offset_i != lat_off);
`endif
    end

    assign div_start = (state == ST_CAP);
    assign busy_o    = div_busy || (state == ST_CAP) || (state == ST_MUL1) ||
                       (state == ST_MUL2) || (state == ST_CALC);
    assign pending_o = (state == ST_PEND);

    scaler_recip_div #(
        .FRAC_W (FRAC_W),
        .DIV_W  (N_OUT_W)
    ) u_div (
        .clk     (SYS_CLK),
        .rst     (SYS_RST),
        .start   (div_start),
        .divisor (lat_out),
        .busy    (div_busy),
        .done    (div_done),
        .quot    (recip)
    );

    always_comb begin
        rnd      = {1'b0, prod} + HALF;
        raw      = RAW_W'(rnd >> FRAC_W);
        needed_c = lat_in;
        pos_base = '0;
        if (raw < RAW_W'(lat_in)) begin
            needed_c = raw[N_IN_W-1:0];
            pos_base = (lat_in - raw[N_IN_W-1:0]) >> 1;
        end
`ifdef CFGGEN_POS_OFFSET_EN
        pos_sum = $signed({2'b00, pos_base}) + $signed({lat_off[N_IN_W], lat_off});
        pos_lim = lat_in - needed_c;
        if (pos_sum < 0) begin
            pos_c = '0;
        end else if (pos_sum > $signed({2'b00, pos_lim})) begin
            pos_c = pos_lim;
        end else begin
            pos_c = pos_sum[N_IN_W-1:0];
        end
`else
        pos_c = pos_base;
`endif
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state           <= ST_IDLE;
            lat_in          <= '0;
            lat_out         <= '0;
            lat_act         <= '0;
`ifdef CFGGEN_POS_OFFSET_EN
            lat_off         <= '0;
`endif
            inv             <= '0;
            prod            <= '0;
            res_needed      <= '0;
            res_pos         <= '0;
            updated_o       <= 1'b0;
            err_o           <= 1'b0;
            interp_factor_o <= '0;
            n_in_needed_o   <= '0;
            n_in_full_o     <= '0;
            n_out_o         <= '0;
            pos_1st_o       <= '0;
        end else begin
            updated_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (changed || force_i) begin
                        lat_in  <= n_in_full_i;
                        lat_out <= n_out_i;
                        lat_act <= n_active_i;
`ifdef CFGGEN_POS_OFFSET_EN
                        lat_off <= pos_offset_i;
`endif
                        // Latching the zero divisor stops the change detector re-firing every cycle.
                        if (n_out_i == '0) begin
                            err_o <= 1'b1;
                        end else begin
                            state <= ST_CAP;
                        end
                    end
                end
                ST_CAP:  state <= ST_DIV;
                ST_DIV:  if (div_done) state <= ST_MUL1;
                ST_MUL1: begin
                    inv   <= INV_W'(recip) * INV_W'(lat_in);
                    state <= ST_MUL2;
                end
                ST_MUL2: begin
                    prod  <= PROD_W'(inv) * PROD_W'(lat_act);
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    res_needed <= needed_c;
                    res_pos    <= pos_c;
                    state      <= ST_PEND;
                end
                ST_PEND: begin
                    // apply_i has priority: the frame boundary takes whatever is pending.
                    if (apply_i) begin
                        interp_factor_o <= recip;
                        n_in_needed_o   <= res_needed;
                        n_in_full_o     <= lat_in;
                        n_out_o         <= lat_out;
                        pos_1st_o       <= res_pos;
                        updated_o       <= 1'b1;
                        err_o           <= 1'b0;
                        state           <= ST_IDLE;
                    end else if (changed) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_axis_cfggen.sv
// Directed self-checking bench for scaler_axis_cfggen (horizontal widths, FRAC_W=17).
module tb_scaler_axis_cfggen;

    localparam int N_IN_W  = 10;
    localparam int N_OUT_W = 12;
    localparam int FRAC_W  = 17;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_IN_W-1:0]   n_in_full;
    logic [N_OUT_W-1:0]  n_out;
    logic [N_OUT_W-1:0]  n_active;
`ifdef CFGGEN_POS_OFFSET_EN
    logic signed [N_IN_W:0] pos_offset;
`endif
    logic                force_r;
    logic                apply;
    logic                busy;
    logic                pending;
    logic                updated;
    logic                err;
    logic [FRAC_W:0]     interp;
    logic [N_IN_W-1:0]   needed;
    logic [N_IN_W-1:0]   in_full_o;
    logic [N_OUT_W-1:0]  out_o;
    logic [N_IN_W-1:0]   pos;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    scaler_axis_cfggen #(
        .N_IN_W  (N_IN_W),
        .N_OUT_W (N_OUT_W),
        .FRAC_W  (FRAC_W)
    ) dut (
        .SYS_CLK         (clk),
        .SYS_RST         (rst),
        .n_in_full_i     (n_in_full),
        .n_out_i         (n_out),
        .n_active_i      (n_active),
`ifdef CFGGEN_POS_OFFSET_EN
        .pos_offset_i    (pos_offset),
`endif
        .force_i         (force_r),
        .apply_i         (apply),
        .busy_o          (busy),
        .pending_o       (pending),
        .updated_o       (updated),
        .err_o           (err),
        .interp_factor_o (interp),
        .n_in_needed_o   (needed),
        .n_in_full_o     (in_full_o),
        .n_out_o         (out_o),
        .pos_1st_o       (pos)
    );

    always @(posedge clk) if (!rst && updated) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pend(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            tick();
            got = pending;
        end
        chk({tag, "_pend"}, {31'd0, got}, 32'd1);
    endtask

    task automatic do_apply();
        apply = 1'b1;
        tick();
        apply = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int f, input int nd, input int p);
        chk({tag, "_interp"}, 32'(interp), 32'(f));
        chk({tag, "_needed"}, 32'(needed), 32'(nd));
        chk({tag, "_pos"},    32'(pos),    32'(p));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  u0;
        logic saw_busy;
        logic got;

        rst = 1'b1; n_in_full = 10'd240; n_out = 12'd480; n_active = 12'd480;
`ifdef CFGGEN_POS_OFFSET_EN
        pos_offset = '0;
`endif
        force_r = 1'b0; apply = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_interp",  32'(interp),    0);
        chk("rst_needed",  32'(needed),    0);
        chk("rst_in_full", 32'(in_full_o), 0);
        chk("rst_pos",     32'(pos),       0);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_pending", 32'(pending),   0);
        chk("rst_err",     32'(err),       0);

        // Auto-start after reset; busy spans CAP plus FRAC_W+4 cycles from divider start to PEND.
        rst = 1'b0;
        cyc = 0; got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            tick();
            if (busy) cyc++;
            got = pending;
        end
        chk("t1_pend", 32'(got), 1);
        chk("t1_latency", 32'(cyc - 1), FRAC_W + 4);
        chk("t1_uncommitted", 32'(interp), 0);
        do_apply();
        chk("t1_updated", 32'(updated), 1);
        chk_res("t1", 273, 240, 0);
        chk("t1_in_full_o", 32'(in_full_o), 240);
        chk("t1_out_o", 32'(out_o), 480);
        chk("t1_pend_clr", 32'(pending), 0);
        tick();
        chk("t1_updated_pulse", 32'(updated), 0);

        // Upscale into a 1080 active window of 1200.
        n_out = 12'd1200; n_active = 12'd1080;
        wait_pend("t2");
        do_apply();
        chk_res("t2", 109, 216, 12);
        chk("t2_out_o", 32'(out_o), 1200);

        // Divide by zero: error, no busy, outputs held.
        n_out = 12'd0;
        saw_busy = 1'b0;
        repeat (30) begin
            tick();
            saw_busy = saw_busy | busy;
        end
        chk("t3_err", 32'(err), 1);
        chk("t3_no_busy", 32'(saw_busy), 0);
        chk_res("t3_hold", 109, 216, 12);
        chk("t3_out_o_hold", 32'(out_o), 1200);
        n_out = 12'd480; n_active = 12'd480;
        wait_pend("t3b");
        chk("t3_err_until_commit", 32'(err), 1);
        do_apply();
        chk("t3_err_clr", 32'(err), 0);
        chk_res("t3b", 273, 240, 0);

        // Changes mid-DIV and in PEND must never commit stale data.
        tick();
        u0 = upd_cnt;
        n_active = 12'd400;
        repeat (10) tick();
        n_active = 12'd360;
        wait_pend("t4a");
        chk("t4a_hold", 32'(needed), 240);
        wait_pend("t4b");
        n_active = 12'd320;
        repeat (3) tick();
        chk("t4_discard", 32'(pending), 0);
        chk("t4_hold", 32'(needed), 240);
        wait_pend("t4c");
        chk("t4_no_commits", 32'(upd_cnt), 32'(u0));
        do_apply();
        chk("t4_updated", 32'(updated), 1);
        chk_res("t4", 273, 160, 40);

        // Reset during MUL1 aborts and clears, then recomputation completes.
        n_active = 12'd480;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = busy;
        end
        chk("t5_busy", 32'(got), 1);
        repeat (FRAC_W + 2) tick();
        rst = 1'b1;
        tick();
        chk_res("t5_rst", 0, 0, 0);
        chk("t5_rst_out_o", 32'(out_o), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_pending", 32'(pending), 0);
        rst = 1'b0;
        wait_pend("t5");
        do_apply();
        chk_res("t5", 273, 240, 0);

        // apply outside PEND does nothing; force recomputes unchanged inputs.
        tick();
        do_apply();
        chk("t6_idle_apply", 32'(updated), 0);
        force_r = 1'b1;
        tick();
        force_r = 1'b0;
        chk("t6_force_busy", 32'(busy), 1);
        wait_pend("t6");
        do_apply();
        chk("t6_updated", 32'(updated), 1);

        // Change coinciding with apply: stale result commits, then retriggers.
        tick();
        force_r = 1'b1;
        tick();
        force_r = 1'b0;
        wait_pend("t7");
        n_active = 12'd400;
        do_apply();
        chk("t7_updated", 32'(updated), 1);
        chk_res("t7_stale", 273, 240, 0);
        wait_pend("t7b");
        do_apply();
        chk_res("t7b", 273, 200, 20);

`ifdef CFGGEN_POS_OFFSET_EN
        // PAL-boxed offset: clamps at full height, shifts when there is slack.
        n_in_full = 10'd288; n_active = 12'd480; pos_offset = 11'sd24;
        wait_pend("t8");
        do_apply();
        chk_res("t8_clamp", 273, 288, 0);
        n_active = 12'd400;
        wait_pend("t8b");
        do_apply();
        chk_res("t8_shift", 273, 240, 48);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scaler_axis_cfggen.md
Name: scaler_axis_cfggen

Overview:
- Parametrised, single-axis successor to the fixed V/H scaler config generator. Instantiate once per axis: vertical with N_IN_W=10, N_OUT_W=11; horizontal with N_IN_W=10, N_OUT_W=12.
- Computes the interpolation factor, the number of input samples needed, and the first input sample to read, from input size, scaled output size and active output window.
- Adds synchronous reset, busy/pending/error status, and frame-boundary-synchronised output update through apply_i. Output fields never change mid-frame.

Parameters:
- N_IN_W, 10, width of input sample counts.
- N_OUT_W, 12, width of output sample counts.
- FRAC_W, 17, fraction bits of the reciprocal; the dividend is 2^FRAC_W.

Ports:
- SYS_CLK  in  1  system clock.
- SYS_RST  in  1  synchronous reset, active-high.
- n_in_full_i  in  N_IN_W  input samples per axis (e.g. 240, 288, 480, 640).
- n_out_i  in  N_OUT_W  total scaled output size (divisor).
- n_active_i  in  N_OUT_W  active output window size.
- force_i  in  1  recompute request, even if inputs are unchanged.
- apply_i  in  1  frame-boundary strobe; commits a pending result.
- busy_o  out  1  high in CAP/DIV/MUL1/MUL2/CALC.
- pending_o  out  1  high in PEND.
- updated_o  out  1  one-cycle pulse when outputs are committed.
- err_o  out  1  sticky divide-by-zero flag.
- interp_factor_o  out  FRAC_W+1  floor(2^FRAC_W / n_out).
- n_in_needed_o  out  N_IN_W  input samples needed.
- n_in_full_o  out  N_IN_W  committed n_in_full.
- n_out_o  out  N_OUT_W  committed n_out.
- pos_1st_o  out  N_IN_W  first input sample to read.

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; latched input copies 0.
  - After reset the nonzero inputs differ from the latched copies, so a computation starts automatically.
  - SYS_RST asserted mid-operation aborts the computation; nothing is committed.
- State IDLE:
  - Trigger: any input differs from its latched copy, or force_i=1.
  - On trigger: latch all inputs, go to CAP.
  - If the latched n_out is 0: set err_o, stay IDLE, outputs unchanged. err_o clears on the next successful commit.
- State CAP (1 cycle): load the divider.
- State DIV (FRAC_W+1 cycles): restoring serial divide, one quotient bit per cycle, giving recip = floor(2^FRAC_W / n_out).
- State MUL1 (1 cycle): inv = recip * n_in_full; full width, no truncation.
- State MUL2 (1 cycle): prod = inv * n_active.
- State CALC (1 cycle):
  - raw = (prod + 2^(FRAC_W-1)) >> FRAC_W, i.e. round half up.
  - needed = min(raw, n_in_full).
  - pos = (raw < n_in_full) ? (n_in_full - raw) >> 1 : 0.
- State PEND: hold results.
  - Commit: on apply_i=1, all outputs load at the next edge, updated_o pulses for that one cycle, go to IDLE.
  - Latency: trigger to pending_o = FRAC_W+4 cycles (21 at defaults).
- Input change while busy: the current run completes to PEND. The mismatch is handled as follows:
  - Seen in PEND: discard the pending result and go to IDLE, which retriggers. Stale results are never committed.
  - Same cycle as apply_i in PEND: apply_i wins and commits the stale result; the change retriggers on the next IDLE cycle.
- force_i in any state other than IDLE is ignored.
- apply_i outside PEND: no effect.

Optional Feature:
- CFGGEN_POS_OFFSET_EN
- With the macro: adds input pos_offset_i (signed, N_IN_W+1 bits).
  - CALC computes pos = clamp(pos_base + pos_offset_i, 0, n_in_full - needed).
  - This supports PAL-boxed centring, e.g. offset 24/48.
  - pos_offset_i is part of the change-detect set.
- Without the macro: the port is absent; pos = pos_base.

Decomposition:
- Shared package / include (extend the existing video-params include):
  - state encoding (IDLE, CAP, DIV, MUL1, MUL2, CALC, PEND);
  - default FRAC_W;
  - per-axis width constants.
- One sub-module: scaler_recip_div, the parametrised restoring serial divider with start/busy/done and synchronous reset.
- Multiplies are inline and registered, with DSP inference.

Test Plan:
- Defaults; n_in_full=240, n_out=480, n_active=480; apply_i after pending → interp_factor_o=273, n_in_needed_o=240, pos_1st_o=0, updated_o one pulse, pending latency 21 cycles.
- n_in_full=240, n_out=1200, n_active=1080 → interp_factor_o=109, n_in_needed_o=216, pos_1st_o=12.
- n_out=0 → err_o=1, outputs keep previous values, busy_o never asserts; then n_out=480 → err_o clears at commit.
- Change n_active mid-DIV, then again while in PEND without apply_i → no commit of stale data; final commit reflects the last inputs only.
- SYS_RST during MUL1 → next cycle all outputs 0 and state IDLE; then recomputation completes normally.
- With CFGGEN_POS_OFFSET_EN, n_in_full=288, n_out=480, n_active=480 (raw=288): offset +24 → pos_1st_o clamps to 0. With n_active=400 (raw=240): pos_base=24, offset +24 → pos_1st_o=48.
